// File: rtl/linear_regression_pkg.sv
// linear_regression_pkg
// Shared widths, the fit FSM state encoding and the 32-bit saturation helper
// used by linear_regression_fit and its sequential divider.
package linear_regression_pkg;

    localparam int DEF_DIV_W      = 80;
    localparam int DEF_SAMPLE_LOG = 8;
    localparam int SIZE_W         = 16;
    localparam int PRICE_W        = 32;

    // Saturation input width; DIV_W values are sign-extended up to this.
    localparam int SAT_IN_W = 128;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = {{(SAT_IN_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = {{(SAT_IN_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV1,
        ICPT,
        DIV2,
        DONE
    } fit_state_t;

    function automatic logic signed [31:0] sat32(input logic signed [SAT_IN_W-1:0] v);
        if (v > SAT_MAX) return 32'sh7fff_ffff;
        if (v < SAT_MIN) return 32'sh8000_0000;
        return v[31:0];
    endfunction

endpackage

// File: rtl/linear_regression_fit_div.sv
// seq_divider
// Restoring, one-quotient-bit-per-cycle signed divider, sign-magnitude:
// magnitudes are divided and the quotient sign is the XOR of operand signs,
// giving truncation toward zero. done pulses exactly W cycles after start.
// Ports: clk, rst (async high), start, dividend, divisor -> done, quotient.
module seq_divider
    import linear_regression_pkg::*;
#(
    parameter int W = DEF_DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic                done,
    output logic signed [W-1:0] quotient
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, quo_q, dsr_q;
    logic          neg_q, run_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  a_mag, b_mag;
    logic [W-1:0]  rem_in, quo_in, dsr_in;
    logic [W:0]    shifted, diff;
    logic [W-1:0]  rem_nx, quo_nx;

    assign a_mag = dividend[W-1] ? -dividend : dividend;
    assign b_mag = divisor[W-1]  ? -divisor  : divisor;

    // The first iteration runs on the start edge itself so the W-th
    // quotient bit is ready exactly W cycles after start.
    always_comb begin
        rem_in  = start ? '0    : rem_q;
        quo_in  = start ? a_mag : quo_q;
        dsr_in  = start ? b_mag : dsr_q;
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {1'b0, dsr_in};
        if (shifted >= {1'b0, dsr_in}) begin
            rem_nx = diff[W-1:0];
            quo_nx = {quo_in[W-2:0], 1'b1};
        end else begin
            rem_nx = shifted[W-1:0];
            quo_nx = {quo_in[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            neg_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            dsr_q <= b_mag;
            neg_q <= dividend[W-1] ^ divisor[W-1];
            run_q <= 1'b1;
            cnt_q <= CW'(W - 1);
        end else if (run_q) begin
            if (cnt_q != '0) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign done     = run_q && (cnt_q == '0);
    assign quotient = neg_q ? -signed'(quo_q) : signed'(quo_q);

endmodule

// File: rtl/linear_regression_fit.sv
// linear_regression_fit
// Accumulates (size, price) samples and, on fit_start, computes the integer
// least-squares slope and intercept with one shared sequential divider.
// Ports: clk, rst (async high), clear, sample_valid/sample_ready, size, price,
//        fit_start, busy, fit_valid, fit_error, slope, intercept, count.
module linear_regression_fit
    import linear_regression_pkg::*;
#(
    parameter int SAMPLE_LOG = DEF_SAMPLE_LOG,
    parameter int DIV_W      = DEF_DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SIZE_W-1:0]   size,
    input  logic [PRICE_W-1:0]  price,
    input  logic                fit_start,
    output logic                busy,
    output logic                fit_valid,
    output logic                fit_error,
    output logic signed [31:0]  slope,
    output logic signed [31:0]  intercept,
    output logic [SAMPLE_LOG:0] count
);
    typedef logic signed [DIV_W-1:0] acc_t;

    fit_state_t state, state_next;
    acc_t sx, sy, sxx, sxy;
    acc_t xv, yv, n, num, den, icpt_num, slope_full;
    acc_t div_a, div_b, div_q;
    logic accept, prep_err, div_start, div_done;
    logic signed [SAT_IN_W-1:0] slope_wide, q_wide;

    assign busy = (state != IDLE);
    // count never exceeds 2^SAMPLE_LOG, so its top bit alone marks "full".
    assign sample_ready = !busy && !count[SAMPLE_LOG] && !clear;
    assign accept       = sample_valid && sample_ready;

    assign xv       = acc_t'(size);
    assign yv       = acc_t'(price);
    assign n        = acc_t'(count);
    assign num      = n * sxy - sx * sy;
    assign den      = n * sxx - sx * sx;
    assign icpt_num = sy - slope_full * sx;
    assign prep_err = (count < (SAMPLE_LOG+1)'(2)) || (den == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx <= '0; sy <= '0; sxx <= '0; sxy <= '0;
            count <= '0;
        end else if (clear && !busy) begin
            sx <= '0; sy <= '0; sxx <= '0; sxy <= '0;
            count <= '0;
        end else if (accept) begin
            sx    <= sx + xv;
            sy    <= sy + yv;
            sxx   <= sxx + xv * xv;
            sxy   <= sxy + xv * yv;
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        div_a      = num;
        div_b      = den;
        case (state)
            IDLE: if (fit_start) state_next = PREP;
            PREP: begin
                if (prep_err) begin
                    state_next = DONE;
                end else begin
                    div_start  = 1'b1;
                    state_next = DIV1;
                end
            end
            DIV1: if (div_done) state_next = ICPT;
            ICPT: begin
                div_start  = 1'b1;
                div_a      = icpt_num;
                div_b      = n;
                state_next = DIV2;
            end
            DIV2: if (div_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_a),
        .divisor  (div_b),
        .done     (div_done),
        .quotient (div_q)
    );

    assign slope_wide = SAT_IN_W'(slope_full);
    assign q_wide     = SAT_IN_W'(div_q);

    // Outputs are written on the edge into DONE so they are valid together
    // with fit_valid. The unsaturated slope feeds the intercept numerator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slope_full <= '0;
            slope      <= '0;
            intercept  <= '0;
            fit_error  <= 1'b0;
        end else begin
            case (state)
                PREP: if (prep_err) begin
                    slope     <= '0;
                    intercept <= '0;
                    fit_error <= 1'b1;
                end
                DIV1: if (div_done) slope_full <= div_q;
                DIV2: if (div_done) begin
                    slope     <= sat32(slope_wide);
                    intercept <= sat32(q_wide);
                    fit_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign fit_valid = (state == DONE);

endmodule

// File: tb/tb_linear_regression_fit.sv
module tb_linear_regression_fit;
    logic clk = 1'b0;
    logic rst, clear, sample_valid, fit_start;
    logic [15:0] size;
    logic [31:0] price;
    logic sample_ready, busy, fit_valid, fit_error;
    logic signed [31:0] slope, intercept;
    logic [8:0] count;

    always #5 clk = ~clk;

    linear_regression_fit dut (
        .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .size(size), .price(price),
        .fit_start(fit_start), .busy(busy), .fit_valid(fit_valid),
        .fit_error(fit_error), .slope(slope), .intercept(intercept),
        .count(count)
    );

    typedef struct {
        longint slope;
        longint icpt;
        longint err;
        longint due;
    } exp_t;

    exp_t   sb[$];
    longint xs[$];
    longint ys[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    exp_t   mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Least-squares reference straight from the normal equations.
    function automatic exp_t model();
        exp_t e;
        longint n, sx, sy, sxx, sxy, num, den, s;
        n = xs.size();
        sx = 0; sy = 0; sxx = 0; sxy = 0;
        foreach (xs[i]) begin
            sx  += xs[i];
            sy  += ys[i];
            sxx += xs[i] * xs[i];
            sxy += xs[i] * ys[i];
        end
        num = n * sxy - sx * sy;
        den = n * sxx - sx * sx;
        e.due = 0;
        if (n < 2 || den == 0) begin
            e.slope = 0; e.icpt = 0; e.err = 1;
        end else begin
            s = num / den;
            e.slope = sat(s);
            e.icpt  = sat((sy - s * sx) / n);
            e.err   = 0;
        end
        return e;
    endfunction

    // Scoreboard monitor: every fit_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && fit_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_fit_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("slope", slope, mon_e.slope);
                check("intercept", intercept, mon_e.icpt);
                check("fit_error", fit_error, mon_e.err);
                check("fit_valid_cycle", cyc, mon_e.due);
                check("busy_at_valid", busy, 1);
                check("ready_at_valid", sample_ready, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; fit_start = 1'b0;
        size = '0; price = '0;
        repeat (2) tick();
        rst = 1'b0;
        xs.delete(); ys.delete();
    endtask

    task automatic send(longint x, longint y, bit acc);
        sample_valid = 1'b1; size = 16'(x); price = 32'(y);
        #0;
        check("sample_ready", sample_ready, acc);
        if (acc) begin xs.push_back(x); ys.push_back(y); end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_clear(bit effective);
        clear = 1'b1;
        #1;
        check("ready_during_clear", sample_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        if (effective) begin xs.delete(); ys.delete(); end
    endtask

    task automatic start_fit(bit expect_result, bit with_s, longint x, longint y);
        exp_t e;
        if (with_s) begin
            sample_valid = 1'b1; size = 16'(x); price = 32'(y);
            xs.push_back(x); ys.push_back(y);
        end
        e = model();
        e.due = cyc + ((e.err != 0) ? 2 : 163);
        if (expect_result) sb.push_back(e);
        fit_start = 1'b1;
        tick();
        fit_start = 1'b0; sample_valid = 1'b0;
        check("busy_cycle1", busy, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("fit_completed", sb.size(), 0);
        check("idle_after_fit", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_slope", slope, 0);
        check("rst_intercept", intercept, 0);
        check("rst_fit_error", fit_error, 0);
        check("rst_fit_valid", fit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_ready", sample_ready, 1);

        // Exact fit: slope 100, intercept 500.
        send(32, 3700, 1); send(100, 10500, 1); send(50, 5500, 1);
        check("count_3", count, 3);
        start_fit(1, 0, 0, 0); wait_done();

        // Truncation, then negative slope.
        do_clear(1);
        send(0, 0, 1); send(1, 1, 1); send(2, 3, 1);
        start_fit(1, 0, 0, 0); wait_done();
        do_clear(1);
        check("count_cleared", count, 0);
        send(0, 10, 1); send(10, 0, 1);
        start_fit(1, 0, 0, 0); wait_done();

        // Error cases: single sample, zero denominator.
        do_clear(1);
        send(7, 70, 1);
        start_fit(1, 0, 0, 0); wait_done();
        do_clear(1);
        send(50, 1, 1); send(50, 9, 1);
        start_fit(1, 0, 0, 0); wait_done();

        // fit_start together with the third sample.
        do_clear(1);
        send(3, 40, 1); send(9, 100, 1);
        start_fit(1, 1, 20, 250); wait_done();
        check("count_with_start", count, 3);

        // Samples and clear offered during a fit are dropped.
        start_fit(1, 0, 0, 0);
        send(5, 5, 0); send(6, 6, 0);
        do_clear(0);
        send(7, 7, 0);
        wait_done();
        check("count_after_drops", count, 3);
        start_fit(1, 0, 0, 0); wait_done();

        // Randomized fits, some with degenerate x.
        for (int r = 0; r < 12; r++) begin
            int n;
            longint x0;
            do_clear(1);
            n  = $urandom_range(1, 12);
            x0 = $urandom_range(0, 4095);
            for (int k = 0; k < n; k++)
                send((r % 5 == 0) ? x0 : longint'($urandom_range(0, 4095)),
                     $urandom_range(0, 1 << 20), 1);
            start_fit(1, 0, 0, 0); wait_done();
        end

        // Capacity limit: 257th sample is dropped.
        do_clear(1);
        for (int k = 0; k < 256; k++)
            send($urandom_range(0, 255), $urandom_range(0, 65535), 1);
        send(1, 1, 0);
        check("count_full", count, 256);
        check("ready_full", sample_ready, 0);
        start_fit(1, 0, 0, 0); wait_done();

        // Reset in DIV1 aborts the fit without fit_valid.
        do_clear(1);
        send(10, 300, 1); send(20, 500, 1); send(40, 950, 1);
        start_fit(0, 0, 0, 0);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("midrst_slope", slope, 0);
        check("midrst_intercept", intercept, 0);
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fit_valid", fit_valid, 0);
        repeat (2) tick();
        rst = 1'b0;
        xs.delete(); ys.delete();
        repeat (170) tick();
        send(10, 300, 1); send(20, 500, 1); send(40, 950, 1);
        start_fit(1, 0, 0, 0); wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/linear_regression_fit.md
# linear_regression_fit

Sequential least-squares trainer for the `linear_regression` predictor. It accumulates `(size, price)` sample pairs one per clock. On request it computes the integer slope and intercept of the best-fit line `price = slope*size + intercept`. These are the coefficients the predictor consumes. It runs in the same single clock domain as the predictor datapath, and its divisions use a shared sequential divider.

## Interface
Parameters:
- `SAMPLE_LOG`, default 8: log2 of the maximum sample count (256).
- `DIV_W`, default 80: internal signed working width and divider iteration count.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clear`, input, 1: synchronous clear of the accumulators and count.
- `sample_valid`, input, 1: a sample is present this cycle.
- `sample_ready`, output, 1: a sample will be accepted this cycle.
- `size`, input, 16: unsigned sample x.
- `price`, input, 32: unsigned sample y.
- `fit_start`, input, 1: request a fit, one-cycle pulse.
- `busy`, output, 1: a fit is in progress.
- `fit_valid`, output, 1: one-cycle pulse when the results are updated.
- `fit_error`, output, 1: error flag, valid with `fit_valid`.
- `slope`, output, 32: signed result.
- `intercept`, output, 32: signed result.
- `count`, output, SAMPLE_LOG+1: number of accepted samples.

## Operation
- **Accumulators:** N (`count`), Sx, Sy, Sxx, Sxy. Each is DIV_W bits signed with zero-extended inputs, so it never overflows at 2^SAMPLE_LOG samples.
- **Sample acceptance:** a sample is accepted when `sample_valid && sample_ready`.
- **`sample_ready` rule:** `sample_ready = !busy && count < 2^SAMPLE_LOG && !clear`. Samples offered while `sample_ready` is low are dropped silently.
- **`clear`:** zeroes the accumulators and `count` unless `busy`. It is ignored while busy. `slope`, `intercept` and `fit_error` keep their last values.
- **Start with a sample:** if `fit_start` and an accepted sample fall in the same cycle, the sample is included in the fit.
- **Start while busy:** `fit_start` is ignored while `busy`.
- **FSM states:** IDLE, PREP, DIV1, ICPT, DIV2, DONE.
  - **IDLE:** on `fit_start`, go to PREP.
  - **PREP:** register `num = N*Sxy - Sx*Sy` and `den = N*Sxx - Sx*Sx`. If N<2 or den==0, go to DONE with the error flag set. Otherwise start the divider on num/den and go to DIV1.
  - **DIV1:** wait for divider done. The quotient becomes the slope. Go to ICPT.
  - **ICPT:** register `Sy - slope*Sx`, start the divider on that value divided by N, and go to DIV2.
  - **DIV2:** wait for divider done. The quotient becomes the intercept. Go to DONE.
  - **DONE:** update the outputs and pulse `fit_valid` for one cycle, then return to IDLE.
- **Division:** signed, truncating toward zero. The divider works sign-magnitude: it divides magnitudes, and the quotient sign is the XOR of the operand signs.
- **Output saturation:** results are saturated to the signed 32-bit range [-2^31, 2^31-1] before being written to `slope`/`intercept`.
- **Error result:** on error, `slope=0`, `intercept=0`, `fit_error=1`.
- **Accumulators after a fit:** they are preserved after a fit, so further samples may be added and the fit re-run.

## Timing
- **Reset values:** all outputs are 0, except `sample_ready=1`. The FSM resets to IDLE and the accumulators to 0.
- **Reset mid-fit:** reset at any state aborts the fit immediately. No `fit_valid` is produced.
- **Divider latency:** exactly DIV_W cycles from its start pulse to its done pulse.
- **Latency counting:** both figures below count from the cycle in which `fit_start` is sampled, as cycle 0.
  - **Normal fit:** `fit_valid` is high in cycle 2*DIV_W+3 (163 at the default).
  - **Error fit:** `fit_valid` is high in cycle 2.
- **`busy`:** high from cycle 1 through the `fit_valid` cycle inclusive.
- **`sample_ready`:** low during the same cycles as `busy`.
- **`count`:** updates the cycle after acceptance.

## Structure
- **`linear_regression_pkg`:**
  - Default widths: `DIV_W`, `SAMPLE_LOG`, input widths 16/32.
  - FSM state enum.
  - A saturate-to-32 function.
- **`seq_divider`:** one sub-module, a restoring, one-bit-per-cycle DIV_W-bit signed divider.
  - Ports: start, dividend, divisor, done, quotient.
  - It is instantiated once and reused for both divisions.

## Test plan
- **Exact fit:** reset, then samples (32,3700), (100,10500), (50,5500), then `fit_start`. Required: after 163 cycles `fit_valid`=1, `slope`=100, `intercept`=500, `fit_error`=0.
- **Truncation and negative slope:**
  - Samples (0,0), (1,1), (2,3) → `slope`=1 (1.5 truncated), `intercept`=0.
  - `clear`, then samples (0,10), (10,0) → `slope`=-1, `intercept`=10.
- **Error cases:**
  - A single sample → `fit_valid` in cycle 2 with `fit_error`=1, `slope`=`intercept`=0.
  - Two samples (50,1), (50,9) → den=0, so `fit_error`=1.
- **Handshake boundaries:**
  - `fit_start` together with the third sample → that sample is included.
  - Samples and `clear` offered during a fit → dropped, `count` unchanged.
  - 257 samples → `count`=256 and `sample_ready`=0.
- **Reset mid-fit:** assert `rst` during DIV1 → outputs return to 0, no `fit_valid`. A new fit after re-loading the samples gives the correct result.
